// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared core types; fetch queue entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  localparam int CORE_XLEN = 32;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of generic entries with flush and head view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import core_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                       clock,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  T                           wdata,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  // Guards keep the occupancy bounded even if a caller misbehaves.
  assign w_do_pop  = pop & ~flush & (r_count != '0);
  assign w_do_push = push & ~flush & ((r_count != CNT_W'(DEPTH)) | w_do_pop);

  always_ff @(posedge clock) begin
    if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch PC sequencer with redirect and a FIFO queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] START_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       mem_en,
  output logic                       imem_req_op,
  output logic [XLEN-1:0]            imem_addr_op,
  input  logic                       imem_gnt_ip,
  input  logic [XLEN-1:0]            imem_rdata_ip,
  input  logic                       redirect_valid_ip,
  input  logic [XLEN-1:0]            redirect_addr_ip,
  input  logic                       stall_ip,
  output logic                       instr_valid_op,
  output logic [XLEN-1:0]            instr_data_op,
  output logic [XLEN-1:0]            instr_pc_addr_op,
  output logic [$clog2(DEPTH+1)-1:0] count_op
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]  r_fetch_pc;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_wentry;
  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_space;
  logic             w_flush;

  // Outputs are gated by reset so the head looks empty while reset is held.
  assign w_valid     = reset & (w_count != '0);
  assign w_pop       = w_valid & ~stall_ip;
  assign w_space     = (w_count != CNT_W'(DEPTH)) | w_pop;
  assign imem_req_op = reset & mem_en & ~redirect_valid_ip & w_space;
  assign w_push      = imem_req_op & imem_gnt_ip;
  assign w_flush     = ~reset | redirect_valid_ip;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fetch_pc <= START_PC;
    end else if (redirect_valid_ip) begin
      r_fetch_pc <= {redirect_addr_ip[XLEN-1:2], 2'b00};
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + XLEN'(4);
    end
  end

  assign w_wentry = '{pc: CORE_XLEN'(r_fetch_pc), instr: CORE_XLEN'(imem_rdata_ip)};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clock (clock),
    .flush (w_flush),
    .push  (w_push),
    .pop   (w_pop & ~redirect_valid_ip),
    .wdata (w_wentry),
    .head  (w_head),
    .count (w_count)
  );

  assign imem_addr_op     = r_fetch_pc;
  assign instr_valid_op   = w_valid;
  assign instr_data_op    = w_valid ? XLEN'(w_head.instr) : '0;
  assign instr_pc_addr_op = w_valid ? XLEN'(w_head.pc) : '0;
  assign count_op         = reset ? w_count : '0;

endmodule

`default_nettype wire
